// File: rtl/scan_mux_pkg.sv
// -----------------------------------------------------------------------------
// scan_mux_pkg
// Shared types and width helpers for the scan multiplexer and its channel
// search logic.
//   state_t    : sequencer state (SHOW = a channel is driven, BLANK = gap).
//   sel_width  : width of a channel index for a given channel count.
//   cnt_width  : width of a counter that must hold the values 0..n.
// -----------------------------------------------------------------------------
package scan_mux_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // A single-channel mux still needs a 1-bit index port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // clog2(n+1), never below 1 bit so a zero-length gap still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// -----------------------------------------------------------------------------
// scan_next_ch
// Combinational round-robin search: finds the first set mask bit strictly
// after i_ch, wrapping circularly, and finally i_ch itself.
// Ports:
//   i_ch    in  SW  current index (values >= CH are tolerated)
//   i_mask  in  CH  1 = candidate
//   o_next  out SW  next candidate index (i_ch when nothing is set)
//   o_wrap  out 1   o_next <= i_ch, i.e. the search wrapped past the top
//   o_any   out 1   at least one mask bit is set
// -----------------------------------------------------------------------------
module scan_next_ch #(
  parameter int CH = 8,
  parameter int SW = 3
) (
  input  logic [SW-1:0] i_ch,
  input  logic [CH-1:0] i_mask,
  output logic [SW-1:0] o_next,
  output logic          o_wrap,
  output logic          o_any
);

  localparam int NP = 2 ** SW;

  // Mask padded to the full index space so any SW-bit index is in range.
  logic [NP-1:0] w_mask_pad;
  assign w_mask_pad = NP'(i_mask);

  always_comb begin
    logic found;
    int   idx;
    o_next = i_ch;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= CH; k++) begin
      // i_ch < 2*CH, so two conditional subtractions implement the modulo.
      idx = int'(i_ch) + k;
      if (idx >= CH) idx = idx - CH;
      if (idx >= CH) idx = idx - CH;
      if (!found && w_mask_pad[SW'(idx)]) begin
        o_next = SW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign o_any  = |i_mask;
  assign o_wrap = (o_next <= i_ch);

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// Registered CH-way multiplexer with a scan sequencer for time-multiplexed
// displays: each unmasked channel is shown for DIV cycles, separated by a
// BLANK-cycle gap with all enables off. Supports a manual-select mode and a
// frame pulse on every wrap of the scan.
// Ports:
//   clk         in  1     rising-edge clock
//   rst_n       in  1     asynchronous active-low reset
//   en          in  1     0 = blank outputs and hold the sequencer
//   mode        in  1     0 = auto scan, 1 = manual select
//   sel_in      in  SW    manual channel index
//   mask        in  CH    1 = channel participates
//   data_in     in  CH*W  channel i at bits [i*W +: W]
//   y           out W     registered selected word
//   an_n        out CH    registered active-low one-hot enable
//   ch          out SW    registered current channel index
//   frame_tick  out 1     one-cycle pulse when the scan wraps
// -----------------------------------------------------------------------------
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int  CH    = 8,
  parameter int  W     = 4,
  parameter int  DIV   = 1000,
  parameter int  BLANK = 2,
  localparam int SW    = sel_width(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel_in,
  input  logic [CH-1:0]   mask,
  input  logic [CH*W-1:0] data_in,
  output logic [W-1:0]    y,
  output logic [CH-1:0]   an_n,
  output logic [SW-1:0]   ch,
  output logic            frame_tick
);

  localparam int PW = cnt_width(DIV);
  localparam int BW = cnt_width(BLANK);
  localparam int NP = 2 ** SW;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blank;
  logic [SW-1:0] r_ch;
  logic [W-1:0]  r_y;
  logic [CH-1:0] r_an_n;
  logic          r_frame;

  state_t        w_state_nx;
  logic [PW-1:0] w_presc_nx;
  logic [BW-1:0] w_blank_nx;
  logic [SW-1:0] w_ch_nx;
  logic          w_frame_nx;
  logic          w_load;
  logic          w_show;
  logic [SW-1:0] w_next;
  logic          w_wrap;
  logic          w_any;

  // Words and mask padded to the full index space: an out-of-range manual
  // index selects an all-zero mask bit and therefore never drives an enable.
  logic [W-1:0]  w_words [NP];
  logic [NP-1:0] w_mask_pad;
  logic [CH-1:0] w_onehot;

  genvar gi;
  for (gi = 0; gi < NP; gi++) begin : g_pad
    if (gi < CH) begin : g_real
      assign w_words[gi]    = data_in[gi*W +: W];
      assign w_mask_pad[gi] = mask[gi];
    end else begin : g_unused
      assign w_words[gi]    = '0;
      assign w_mask_pad[gi] = 1'b0;
    end
  end

  for (gi = 0; gi < CH; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_ch_nx == SW'(gi));
  end

  scan_next_ch #(
    .CH (CH),
    .SW (SW)
  ) u_next (
    .i_ch   (r_ch),
    .i_mask (mask),
    .o_next (w_next),
    .o_wrap (w_wrap),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_nx = r_state;
    w_presc_nx = r_presc;
    w_blank_nx = r_blank;
    w_ch_nx    = r_ch;
    w_frame_nx = 1'b0;
    w_load     = 1'b0;
    if (!en) begin
      w_state_nx = ST_BLANK;
      w_presc_nx = '0;
      w_blank_nx = '0;
    end else if (mode) begin
      // Parked in SHOW with a fresh prescaler so leaving manual mode
      // continues on the selected channel for a full slot.
      w_state_nx = ST_SHOW;
      w_presc_nx = '0;
      w_blank_nx = '0;
      w_ch_nx    = sel_in;
    end else begin
      unique case (r_state)
        ST_SHOW: begin
          if (r_presc == PRESC_LAST) begin
            w_presc_nx = '0;
            if (BLANK == 0) begin
              w_load = 1'b1;
            end else begin
              w_state_nx = ST_BLANK;
              w_blank_nx = '0;
            end
          end else begin
            w_presc_nx = r_presc + 1'b1;
          end
        end
        ST_BLANK: begin
          if ((BLANK == 0) || (r_blank == BLANK_LAST)) begin
            w_blank_nx = '0;
            w_load     = 1'b1;
          end else begin
            w_blank_nx = r_blank + 1'b1;
          end
        end
        default: ;
      endcase
      // With nothing unmasked the sequencer idles in BLANK, re-checking the
      // mask at the end of every gap.
      if (w_load) begin
        if (w_any) begin
          w_ch_nx    = w_next;
          w_state_nx = ST_SHOW;
          w_frame_nx = w_wrap;
        end else begin
          w_state_nx = ST_BLANK;
        end
      end
    end
  end

  // Outputs are derived from the next state so y, an_n and ch change together.
  assign w_show = (w_state_nx == ST_SHOW) && w_mask_pad[w_ch_nx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_presc <= '0;
      r_blank <= '0;
      r_ch    <= '0;
      r_y     <= '0;
      r_an_n  <= '1;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_presc <= w_presc_nx;
      r_blank <= w_blank_nx;
      r_ch    <= w_ch_nx;
      r_frame <= w_frame_nx;
      r_an_n  <= w_show ? ~w_onehot : '1;
      if (w_show) r_y <= w_words[w_ch_nx];
    end
  end

  assign y          = r_y;
  assign an_n       = r_an_n;
  assign ch         = r_ch;
  assign frame_tick = r_frame;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
// Self-checking bench for scan_mux (CH=4, W=4, DIV=4, BLANK=1). A slot-position
// model (position 0..BLANK-1 = gap, BLANK..BLANK+DIV-1 = showing) predicts the
// outputs; every cycle is compared against it, and directed scenarios pin
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_scan_mux;

  localparam int CH    = 4;
  localparam int W     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int SW    = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode;
  logic [SW-1:0]   sel_in;
  logic [CH-1:0]   mask;
  logic [CH*W-1:0] data_in;
  logic [W-1:0]    y;
  logic [CH-1:0]   an_n;
  logic [SW-1:0]   ch;
  logic            frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  scan_mux #(
    .CH    (CH),
    .W     (W),
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .sel_in     (sel_in),
    .mask       (mask),
    .data_in    (data_in),
    .y          (y),
    .an_n       (an_n),
    .ch         (ch),
    .frame_tick (frame_tick)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    int            chn;
    int            pos;
    logic [CH-1:0] an;
    logic [W-1:0]  yv;
    logic          frame;
  } mstate_t;

  mstate_t ms = '{chn: 0, pos: 0, an: '1, yv: '0, frame: 1'b0};

  function automatic int next_unmasked(input int cur);
    for (int k = 1; k <= CH; k++)
      if (mask[(cur + k) % CH]) return (cur + k) % CH;
    return -1;
  endfunction

  function automatic mstate_t shown(input mstate_t s);
    mstate_t n = s;
    if (s.chn < CH && mask[s.chn]) begin
      n.an = ~(CH'(1) << s.chn);
      n.yv = data_in[s.chn*W +: W];
    end else begin
      n.an = '1;
    end
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n = s;
    int nx;
    n.frame = 1'b0;
    if (!en) begin
      n.pos = 0;
      n.an  = '1;
    end else if (mode) begin
      n.chn = int'(sel_in);
      n.pos = BLANK;
      n = shown(n);
    end else begin
      n.pos = (s.pos + 1) % (DIV + BLANK);
      if (n.pos == BLANK) begin
        nx = next_unmasked(s.chn);
        if (nx < 0) begin
          n.pos = 0;
        end else begin
          n.frame = (nx <= s.chn);
          n.chn   = nx;
        end
      end
      if (n.pos >= BLANK) n = shown(n);
      else n.an = '1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '{chn: 0, pos: 0, an: '1, yv: '0, frame: 1'b0};
    else        ms <= model_next(ms);
  end

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge, then check every output vs the model.
  task automatic tick();
    @(negedge clk);
    cmp("model_y", int'(y), int'(ms.yv));
    cmp("model_an_n", int'(an_n), int'(ms.an));
    cmp("model_ch", int'(ch), ms.chn);
    cmp("model_frame", int'(frame_tick), int'(ms.frame));
  endtask

  initial begin
    int            cnt;
    int            bad;
    int            k;
    int            c0;
    int            e;
    logic [CH-1:0] exp_an;

    rst_n   = 1'b0;
    en      = 1'b1;
    mode    = 1'b0;
    sel_in  = '0;
    mask    = 4'hF;
    data_in = 16'hDCBA;
    repeat (3) tick();
    cmp("rst_an_n", int'(an_n), 'hF);
    cmp("rst_ch", int'(ch), 0);
    cmp("rst_y", int'(y), 0);
    cmp("rst_frame", int'(frame_tick), 0);

    // 1: full scan
    rst_n = 1'b1;
    tick();
    $display("scan: first load ch=%0d an_n=%b y=%h", ch, an_n, y);
    cmp("t1_ch", int'(ch), 1);
    cmp("t1_an", int'(an_n), 'b1101);
    cmp("t1_y", int'(y), 'hB);
    repeat (3) tick();
    cmp("t1_hold_an", int'(an_n), 'b1101);
    tick();
    cmp("t1_blank_an", int'(an_n), 'hF);
    cmp("t1_blank_y", int'(y), 'hB);
    tick();
    cmp("t1_ch2", int'(ch), 2);
    cmp("t1_an2", int'(an_n), 'b1011);
    cmp("t1_y2", int'(y), 'hC);
    cnt = 0;
    bad = 0;
    repeat (40) begin
      tick();
      if (frame_tick) begin
        cnt++;
        if (ch != 0) bad++;
      end
    end
    $display("scan: %0d frame pulses in 40 cycles", cnt);
    cmp("t1_frames", cnt, 2);
    cmp("t1_frame_ch0", bad, 0);

    // 2: sparse mask 0101
    mask = 4'b0101;
    repeat (10) tick();
    cnt = 0;
    bad = 0;
    repeat (40) begin
      tick();
      if (an_n[1] == 1'b0 || an_n[3] == 1'b0) bad++;
      if (frame_tick) begin
        cnt++;
        if (ch != 0) bad++;
      end
    end
    $display("mask0101: %0d frame pulses, %0d bad cycles", cnt, bad);
    cmp("t2_frames", cnt, 4);
    cmp("t2_bad", bad, 0);

    // 3: empty mask, then a single channel
    mask = 4'b0000;
    repeat (12) tick();
    c0  = int'(ch);
    cnt = 0;
    repeat (20) begin
      tick();
      if (an_n != 4'hF || int'(ch) != c0 || frame_tick) cnt++;
    end
    cmp("t3_frozen", cnt, 0);
    mask = 4'b1000;
    tick();
    $display("mask1000: ch=%0d an_n=%b y=%h", ch, an_n, y);
    cmp("t3_ch", int'(ch), 3);
    cmp("t3_an", int'(an_n), 'b0111);
    cmp("t3_y", int'(y), 'hD);

    // 4: manual select
    mode   = 1'b1;
    sel_in = 2'd2;
    mask   = 4'hF;
    tick();
    $display("manual: ch=%0d an_n=%b y=%h", ch, an_n, y);
    cmp("t4_ch", int'(ch), 2);
    cmp("t4_an", int'(an_n), 'b1011);
    cmp("t4_y", int'(y), 'hC);
    data_in = 16'hD5BA;
    tick();
    cmp("t4_y5", int'(y), 5);
    mask = 4'b1011;
    tick();
    cmp("t4_masked_an", int'(an_n), 'hF);
    cmp("t4_masked_y", int'(y), 5);
    cmp("t4_frame", int'(frame_tick), 0);
    repeat (20) begin
      sel_in  = 2'($urandom);
      mask    = 4'($urandom);
      data_in = 16'($urandom);
      tick();
    end
    mode    = 1'b0;
    mask    = 4'hF;
    data_in = 16'hDCBA;

    // 5: asynchronous reset mid-SHOW
    k = 0;
    while (an_n == 4'hF && k < 30) begin
      tick();
      k++;
    end
    cmp("t5_reach_show", int'(an_n != 4'hF), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: ch=%0d an_n=%b y=%h", ch, an_n, y);
    cmp("t5_an", int'(an_n), 'hF);
    cmp("t5_ch", int'(ch), 0);
    cmp("t5_y", int'(y), 0);
    cmp("t5_frame", int'(frame_tick), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cmp("t5_restart_ch", int'(ch), 1);
    cmp("t5_restart_an", int'(an_n), 'b1101);

    // 6: enable drop mid-SHOW
    k = 0;
    while (an_n == 4'hF && k < 30) begin
      tick();
      k++;
    end
    cmp("t6_reach_show", int'(an_n != 4'hF), 1);
    c0 = int'(ch);
    en = 1'b0;
    tick();
    cmp("t6_off_an", int'(an_n), 'hF);
    repeat (3) tick();
    cmp("t6_ch_hold", int'(ch), c0);
    en = 1'b1;
    tick();
    e      = (c0 + 1) % CH;
    exp_an = ~(CH'(1) << e);
    $display("en restore: ch=%0d an_n=%b", ch, an_n);
    cmp("t6_adv_ch", int'(ch), e);
    cmp("t6_adv_an", int'(an_n), int'(exp_an));

    // 7: randomized traffic, model-checked every cycle
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel_in = 2'($urandom);
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = 16'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel multiplexer with a built-in scan sequencer.
- Time-multiplexes CH words of W bits onto one output bus, with a one-hot active-low channel enable (e.g. a multi-digit 7-segment driver).
- Adds an anti-ghosting blank interval between channels, a per-channel skip mask, a manual-select mode and a frame pulse.
- Sits between the data registers and the display/pin logic.

Parameters:
- CH, 8, number of channels (>=2).
- W, 4, width of each channel word.
- DIV, 1000, clock cycles each channel is shown (>=1).
- BLANK, 2, clock cycles all enables are off between channels (>=0; 0 = switch directly).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 = outputs blanked, sequencer held.
- mode  in  1  0 = auto scan, 1 = manual select.
- sel_in  in  SW  manual channel index (SW = clog2(CH)).
- mask  in  CH  1 = channel participates; 0 = skipped/blanked.
- data_in  in  CH*W  flattened channel words; channel i = bits [i*W +: W].
- y  out  W  registered selected word.
- an_n  out  CH  registered active-low one-hot enable.
- ch  out  SW  registered current channel index.
- frame_tick  out  1  one-cycle pulse at auto-scan wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- Reset values: y=0, an_n=all ones, ch=0, frame_tick=0, state=BLANK, prescaler=0, blank counter=0.
- States: SHOW and BLANK.
- SHOW:
  - an_n = ~(1<<ch); y = data_in word ch.
  - Both are registered: a data_in change appears on y one cycle later.
  - Prescaler counts 0..DIV-1. At DIV-1, go to BLANK and clear the prescaler.
- BLANK:
  - an_n = all ones; y holds its last value.
  - Lasts BLANK cycles. On the last cycle, ch <= next unmasked channel, circularly after ch; then go to SHOW.
  - With BLANK=0, the transition is SHOW -> SHOW on the next channel; the enable switches in the same cycle as ch and y.
- Next-channel rule: search indices ch+1 .. CH-1, then 0 .. ch. If only ch is unmasked, ch is kept and the BLANK gap still occurs.
- All-zero mask: stay in BLANK with an_n all ones; ch holds; frame_tick stays 0.
- frame_tick: asserted for exactly one cycle, in the same cycle the new ch is loaded, when the new index is <= the old index (wrap). A single-channel mask pulses once per DIV+BLANK cycles.
- Mask change while in SHOW:
  - If mask[ch] drops, an_n for ch goes high on the next clock.
  - The state, prescaler and cycle-by-cycle sequencing continue unchanged; the masked channel simply shows no enable until the next switch.
- en=0: an_n all ones the next cycle; state forced to BLANK; counters cleared; ch holds. On en 0->1, the normal BLANK countdown runs, then the sequencer advances.
- Manual mode (mode=1):
  - Prescaler and blank counter are cleared and frame_tick=0.
  - ch <= sel_in each cycle (1-cycle latency). y and an_n follow ch on the same edge.
  - sel_in >= CH or mask[sel_in]=0 gives an_n all ones; y holds.
- Leaving manual mode: enter SHOW on the current ch with prescaler=0.
- Precedence: rst_n > en=0 > mode=1 > auto sequencing.
- Outputs are glitch-free: all outputs come straight from flops.

Decomposition:
- Package scan_mux_pkg:
  - state enum {SHOW, BLANK};
  - width function giving SW = CH>1 ? clog2(CH) : 1;
  - prescaler width clog2(DIV+1) and blank-counter width clog2(BLANK+1).
- One combinational sub-module, scan_next_ch: inputs ch and mask; outputs next index, a wrap flag and an any-unmasked flag. It is reusable by other round-robin logic.

Test Plan (CH=4, W=4, DIV=4, BLANK=1, data_in=0xDCBA so ch0=A, ch1=B, ch2=C, ch3=D):
1. Reset, mask=1111, en=1, mode=0 -> after 1 blank cycle, ch=1, y=B, an_n=1101 for 4 cycles; then 1 cycle an_n=1111; sequence continues 2,3,0. frame_tick pulses exactly once per 20 cycles, on the 3->0 load.
2. mask=0101 -> ch alternates 0,2 only. Channels 1 and 3 are never enabled; frame_tick fires on the 2->0 load.
3. mask=0000 -> an_n stays 1111 indefinitely with ch frozen. Setting mask=1000 then yields ch=3, an_n=0111 after the blank cycle.
4. mode=1, sel_in=2 -> next cycle ch=2, y=C, an_n=1011. Changing data_in ch2 to 5 gives y=5 one cycle later. Setting mask[2]=0 gives an_n=1111.
5. Assert rst_n=0 mid-SHOW, asynchronously between edges -> outputs reach reset values immediately, without waiting for clk. Releasing reset restarts from ch0 BLANK.
6. en dropped mid-SHOW -> an_n=1111 on the next cycle. Re-raising en gives 1 blank cycle, then advance to the next unmasked channel.
